gba_sound_dmafifo: RTL and testbench
====================================

# gba_sound_dmafifo

Direct Sound FIFO channel (A or B) sitting directly downstream of the timer blocks. It buffers 32-bit sample words written by the CPU or DMA into an 8-word FIFO. On each overflow tick from the selected timer (timer 0 or 1) it pops one signed 8-bit PCM sample. It pulses a DMA request whenever the FIFO drains to half-full or below, feeding the sound mixer and the sound DMA channel.

## Interface
- `index`, 0: channel identity (0 = FIFO A, 1 = FIFO B); affects only `debugout[31]`.
- `clk` in 1: system clock, 16.7 MHz.
- `reset` in 1: synchronous, active-high; clears all state.
- `gb_on` in 1: core enable; when low, all state is frozen (reset still acts).
- `fifo_wr` in 1: one-cycle strobe, push `fifo_din`.
- `fifo_din` in 32: sample word; byte 0 (bits 7:0) is played first.
- `fifo_clear` in 1: one-cycle strobe from the SOUNDCNT_H FIFO-reset bit write.
- `timer_select` in 1: 0 = use `timer0_tick`, 1 = use `timer1_tick`.
- `timer0_tick` in 1: overflow pulse from timer 0.
- `timer1_tick` in 1: overflow pulse from timer 1.
- `sample` out 8: current signed PCM sample; reset 0.
- `sample_valid` out 1: one-cycle pulse when `sample` is updated; reset 0.
- `dma_req` out 1: one-cycle request pulse to sound DMA; reset 0.
- `fill_bytes` out 6: unplayed bytes, 0..32; reset 0.
- `debugout` out 32: see Configuration; reset 0.

## Operation
- Storage is 8 words × 32 bits, with a 3-bit write pointer, a 3-bit read pointer, a 4-bit word count `wcnt` (0..8) and a 2-bit byte index `bidx` within the head word.
- `fill_bytes = wcnt*4 - bidx`, combinational from registered state.
- **Push**: when `fifo_wr` and `wcnt < 8`, store at the write pointer, advance it (mod 8), and increment `wcnt`. When `wcnt == 8` the write is dropped and the overflow event fires. Fullness is evaluated on pre-cycle state, so a pop freeing a slot in the same cycle does not admit the push.
- **Pop**: triggered by `tick_sel = timer_select ? timer1_tick : timer0_tick`.
  - If `wcnt > 0`: `sample <= head[8*bidx+7 : 8*bidx]`, `sample_valid <= 1`, `bidx++`.
  - When `bidx` wraps 3→0, the head word is freed: the read pointer advances and `wcnt` decrements.
  - If `wcnt == 0`: underflow. `sample` holds its value, `sample_valid` stays 0, and the underflow event fires.
- **DMA request**: `dma_req` pulses in the cycle after a pop that frees a word and leaves the post-pop `wcnt <= 4`. Exactly one pulse is produced per freed word. The DMA controller latches the pulse; this block holds no pending state.
- **Simultaneous push and pop** (not full): both take effect, so `wcnt` is net unchanged when the pop frees a word.
- **`fifo_clear`**: pointers, `wcnt` and `bidx` go to 0. A push or pop in the same cycle is discarded. `sample` is held. No `dma_req` is issued.
- **`reset`**: everything in the FIFO clears to 0, including `sample`. Reset mid-operation aborts any push or pop in that cycle.
- **`gb_on` low**: pushes, pops and clears are ignored, and no pulses are produced.
- Word contents are not cleared by `fifo_clear` or `reset`; they are unreachable until rewritten.

## Timing
- Push at edge N: `fill_bytes` reflects it from N+1.
- Tick at edge N: `sample`, `sample_valid` and the new `fill_bytes` are visible from N+1.
- `dma_req` is visible from N+1, in the same cycle as `sample_valid`.
- Pop latency is 1 cycle. Back-to-back ticks on consecutive cycles are supported, at one byte per cycle.
- `timer_select` is sampled every cycle; changing it takes effect on the next tick.

## Configuration
- `GBA_SOUND_FIFO_STATS_EN` defined:
  - `debugout = {index, 7'b0, ovf_cnt[7:0], unf_cnt[7:0], 2'b0, fill_bytes}`.
  - The overflow and underflow counters are 8-bit and saturate at 255.
  - Both counters are cleared by `reset` only.
- `GBA_SOUND_FIFO_STATS_EN` undefined: the counters are absent and `debugout` is constant 0.

## Test plan
- **Basic playback**: after reset, push 0x04030201 and 0x08070605 with `timer_select=0`, then give 8 `timer0_tick` pulses 4 cycles apart. Expect `sample` = 01,02,…,08, each with a `sample_valid` pulse; `fill_bytes` 8→0; a `dma_req` pulse at the 4th and 8th pops.
- **Overflow**: push 9 words. Expect the 9th dropped and `fill_bytes=32`; the stats build shows `ovf_cnt=1`. Then 32 ticks: the popped data matches words 1–8 only.
- **Underflow**: on an empty FIFO with `sample` = 0x7F, give a tick. Expect `sample` to stay 0x7F, no `sample_valid`, and `unf_cnt=1`.
- **Timer select**: with `timer_select=1`, pulse `timer0_tick`. Expect no pop. Then pulse `timer1_tick`: expect a pop.
- **Simultaneous push and pop**: `wcnt=8`, `bidx=3`, with tick and `fifo_wr` in the same cycle. Expect the push rejected and `wcnt=7`. Repeat with `wcnt=5`: expect the push accepted and `wcnt` to stay at 5.
- **Clear versus gb_on**: after 3 words and 2 pops, assert `fifo_clear` together with `fifo_wr`. Expect `fill_bytes=0` and `sample` held. With `gb_on=0`, pushes and ticks leave `fill_bytes` unchanged.

Source files
------------

// File: rtl/gba_sound_dmafifo.sv
// ---------------------------------------------------------------------------
// gba_sound_dmafifo
//
// One Direct Sound FIFO channel (A or B). Sample words from the CPU or the
// sound DMA are buffered in an 8 x 32-bit FIFO. Each overflow tick of the
// selected timer plays one signed 8-bit PCM byte, little-endian within the
// word. A one-cycle DMA request pulse is raised whenever a word is freed and
// the FIFO is left with 4 words or fewer.
//
// Optional feature macro: GBA_SOUND_FIFO_STATS_EN
//   defined   : saturating 8-bit overflow/underflow counters on debugout
//   undefined : no counters, debugout is constant 0
//
// Parameters
//   index        channel identity (0 = FIFO A, 1 = FIFO B), shown on debugout[31]
//
// Ports
//   clk          system clock
//   reset        synchronous active-high reset, clears all state
//   gb_on        core enable; when low, pushes, pops and clears are ignored
//   fifo_wr      one-cycle push strobe for fifo_din
//   fifo_din     32-bit sample word, bits 7:0 are played first
//   fifo_clear   one-cycle FIFO reset strobe
//   timer_select 0 = timer0_tick pops, 1 = timer1_tick pops
//   timer0_tick  overflow pulse of timer 0
//   timer1_tick  overflow pulse of timer 1
//   sample       current signed PCM sample
//   sample_valid one-cycle pulse when sample is updated
//   dma_req      one-cycle request pulse to the sound DMA
//   fill_bytes   unplayed bytes, 0..32
//   debugout     statistics / debug word
//
// Strobe semantics: fifo_wr and the timer ticks are fire-and-forget pulses
// with no ready/backpressure. A push arriving while the FIFO holds 8 words
// is dropped (overflow event); a tick arriving on an empty FIFO is ignored
// (underflow event). Fullness and emptiness are judged on the state before
// the edge, so a same-cycle pop never makes room for a same-cycle push.
// ---------------------------------------------------------------------------
module gba_sound_dmafifo #(
    parameter bit index = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gb_on,
    input  logic        fifo_wr,
    input  logic [31:0] fifo_din,
    input  logic        fifo_clear,
    input  logic        timer_select,
    input  logic        timer0_tick,
    input  logic        timer1_tick,
    output logic [7:0]  sample,
    output logic        sample_valid,
    output logic        dma_req,
    output logic [5:0]  fill_bytes,
    output logic [31:0] debugout
);

    // Word storage; contents are never cleared, only the pointers are.
    logic [31:0] mem [8];

    logic [2:0] wptr;
    logic [2:0] rptr;
    logic [3:0] wcnt;   // whole words held, 0..8
    logic [1:0] bidx;   // next byte to play within the head word

    logic       tick_sel;
    logic       is_full;
    logic       is_empty;
    logic       do_push;
    logic       do_pop;
    logic       frees_word;
    logic [7:0] head_byte;

    assign tick_sel = timer_select ? timer1_tick : timer0_tick;
    assign is_full  = (wcnt == 4'd8);
    assign is_empty = (wcnt == 4'd0);

    // A clear in the same cycle discards any push or pop.
    assign do_push    = gb_on && !fifo_clear && fifo_wr  && !is_full;
    assign do_pop     = gb_on && !fifo_clear && tick_sel && !is_empty;
    assign frees_word = do_pop && (bidx == 2'd3);

    always_comb begin
        head_byte = 8'h00;
        case (bidx)
            2'd0: head_byte = mem[rptr][7:0];
            2'd1: head_byte = mem[rptr][15:8];
            2'd2: head_byte = mem[rptr][23:16];
            2'd3: head_byte = mem[rptr][31:24];
            default: head_byte = 8'h00;
        endcase
    end

    // Unplayed bytes: whole words minus the bytes already taken from the head.
    assign fill_bytes = {wcnt, 2'b00} - {4'b0000, bidx};

    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wptr] <= fifo_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr         <= 3'd0;
            rptr         <= 3'd0;
            wcnt         <= 4'd0;
            bidx         <= 2'd0;
            sample       <= 8'h00;
            sample_valid <= 1'b0;
            dma_req      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            dma_req      <= 1'b0;
            if (gb_on && fifo_clear) begin
                wptr <= 3'd0;
                rptr <= 3'd0;
                wcnt <= 4'd0;
                bidx <= 2'd0;
            end else begin
                if (do_push) begin
                    wptr <= wptr + 3'd1;
                end
                if (do_pop) begin
                    sample       <= head_byte;
                    sample_valid <= 1'b1;
                    bidx         <= bidx + 2'd1;
                end
                if (frees_word) begin
                    rptr <= rptr + 3'd1;
                end
                wcnt <= wcnt + {3'b000, do_push} - {3'b000, frees_word};
                // Request refill when the pop alone leaves 4 words or fewer,
                // i.e. the FIFO held 5 or fewer words before the freeing pop.
                dma_req <= frees_word && (wcnt <= 4'd5);
            end
        end
    end

`ifdef GBA_SOUND_FIFO_STATS_EN
    logic [7:0] ovf_cnt;
    logic [7:0] unf_cnt;
    logic       ovf_evt;
    logic       unf_evt;

    assign ovf_evt = gb_on && !fifo_clear && fifo_wr  && is_full;
    assign unf_evt = gb_on && !fifo_clear && tick_sel && is_empty;

    // Counters saturate at 255 and survive fifo_clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_cnt <= 8'd0;
            unf_cnt <= 8'd0;
        end else begin
            if (ovf_evt && (ovf_cnt != 8'hFF)) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
            if (unf_evt && (unf_cnt != 8'hFF)) begin
                unf_cnt <= unf_cnt + 8'd1;
            end
        end
    end

    assign debugout = {index, 7'b0000000, ovf_cnt, unf_cnt, 2'b00, fill_bytes};
`else
    assign debugout = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_gba_sound_dmafifo.sv
// ---------------------------------------------------------------------------
// tb_gba_sound_dmafifo
//
// Directed bench for gba_sound_dmafifo. Inputs change 1 ns after a rising
// edge; outputs are sampled 1 ns after the next rising edge, i.e. in the
// cycle following the edge that acted on the stimulus.
// ---------------------------------------------------------------------------
module tb_gba_sound_dmafifo;

    logic        clk;
    logic        reset;
    logic        gb_on;
    logic        fifo_wr;
    logic [31:0] fifo_din;
    logic        fifo_clear;
    logic        timer_select;
    logic        timer0_tick;
    logic        timer1_tick;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        dma_req;
    logic [5:0]  fill_bytes;
    logic [31:0] debugout;

    int n_cmp;
    int n_err;

    logic [7:0] exp_q[$];

    gba_sound_dmafifo #(.index(1'b0)) dut (
        .clk          (clk),
        .reset        (reset),
        .gb_on        (gb_on),
        .fifo_wr      (fifo_wr),
        .fifo_din     (fifo_din),
        .fifo_clear   (fifo_clear),
        .timer_select (timer_select),
        .timer0_tick  (timer0_tick),
        .timer1_tick  (timer1_tick),
        .sample       (sample),
        .sample_valid (sample_valid),
        .dma_req      (dma_req),
        .fill_bytes   (fill_bytes),
        .debugout     (debugout)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic push(input logic [31:0] w);
        fifo_wr  = 1'b1;
        fifo_din = w;
        step();
        fifo_wr  = 1'b0;
    endtask

    task automatic tick0();
        timer0_tick = 1'b1;
        step();
        timer0_tick = 1'b0;
    endtask

    task automatic tick1();
        timer1_tick = 1'b1;
        step();
        timer1_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Word whose byte k holds base + 4*i + k.
    function automatic logic [31:0] mkw(input int base, input int i);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(base + 4 * i);
        b1 = 8'(base + 4 * i + 1);
        b2 = 8'(base + 4 * i + 2);
        b3 = 8'(base + 4 * i + 3);
        return {b3, b2, b1, b0};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        n_cmp++; if (sample !== 8'h00) begin n_err++; $display("FAIL reset_sample got %h exp 00", sample); end
        n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", sample_valid); end
        n_cmp++; if (dma_req !== 1'b0) begin n_err++; $display("FAIL reset_dma got %b exp 0", dma_req); end
        n_cmp++; if (fill_bytes !== 6'd0) begin n_err++; $display("FAIL reset_fill got %0d exp 0", fill_bytes); end
        n_cmp++; if (debugout !== 32'h0) begin n_err++; $display("FAIL reset_debugout got %h exp 0", debugout); end
    endtask

    task automatic test_basic_playback();
        logic [7:0] e;
        timer_select = 1'b0;
        push(32'h04030201);
        push(32'h08070605);
        n_cmp++; if (fill_bytes !== 6'd8) begin n_err++; $display("FAIL basic_fill_after_push got %0d exp 8", fill_bytes); end
        for (int i = 0; i < 8; i++) begin
            tick0();
            e = 8'(i + 1);
            n_cmp++; if (sample !== e) begin n_err++; $display("FAIL basic_sample[%0d] got %h exp %h", i, sample, e); end
            n_cmp++; if (sample_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid[%0d] got %b exp 1", i, sample_valid); end
            n_cmp++; if (dma_req !== ((i == 3) || (i == 7))) begin n_err++; $display("FAIL basic_dma[%0d] got %b exp %b", i, dma_req, (i == 3) || (i == 7)); end
            n_cmp++; if (fill_bytes !== 6'(7 - i)) begin n_err++; $display("FAIL basic_fill[%0d] got %0d exp %0d", i, fill_bytes, 7 - i); end
            idle(1);
            n_cmp++; if (sample_valid !== 1'b0 || dma_req !== 1'b0) begin n_err++; $display("FAIL basic_pulse_width[%0d] got valid=%b dma=%b exp 0/0", i, sample_valid, dma_req); end
            idle(2);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] e;
        logic       ed;
        for (int i = 0; i < 9; i++) begin
            push(mkw(8'h10, i));
            if (i < 8) for (int k = 0; k < 4; k++) exp_q.push_back(8'(8'h10 + 4 * i + k));
        end
        n_cmp++; if (fill_bytes !== 6'd32) begin n_err++; $display("FAIL ovf_fill got %0d exp 32", fill_bytes); end
`ifdef GBA_SOUND_FIFO_STATS_EN
        n_cmp++; if (debugout[23:16] !== 8'd1) begin n_err++; $display("FAIL ovf_cnt got %0d exp 1", debugout[23:16]); end
        n_cmp++; if (debugout[5:0] !== 6'd32) begin n_err++; $display("FAIL ovf_dbg_fill got %0d exp 32", debugout[5:0]); end
`endif
        // Back-to-back ticks, one byte per cycle.
        timer0_tick = 1'b1;
        for (int k = 0; k < 32; k++) begin
            step();
            e  = exp_q.pop_front();
            // Freeing word n (1-based) leaves 8-n words; request when <= 4.
            ed = ((k % 4) == 3) && ((8 - (k / 4 + 1)) <= 4);
            n_cmp++; if (sample !== e || sample_valid !== 1'b1) begin n_err++; $display("FAIL ovf_pop[%0d] got %h/%b exp %h/1", k, sample, sample_valid, e); end
            n_cmp++; if (dma_req !== ed) begin n_err++; $display("FAIL ovf_dma[%0d] got %b exp %b", k, dma_req, ed); end
        end
        timer0_tick = 1'b0;
        n_cmp++; if (fill_bytes !== 6'd0) begin n_err++; $display("FAIL ovf_drained got %0d exp 0", fill_bytes); end
    endtask

    task automatic test_underflow();
        push(32'h7F7F7F7F);
        for (int k = 0; k < 4; k++) tick0();
        n_cmp++; if (sample !== 8'h7F || fill_bytes !== 6'd0) begin n_err++; $display("FAIL unf_setup got %h/%0d exp 7f/0", sample, fill_bytes); end
        tick0();
        n_cmp++; if (sample !== 8'h7F) begin n_err++; $display("FAIL unf_sample got %h exp 7f", sample); end
        n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL unf_valid got %b exp 0", sample_valid); end
        n_cmp++; if (fill_bytes !== 6'd0) begin n_err++; $display("FAIL unf_fill got %0d exp 0", fill_bytes); end
`ifdef GBA_SOUND_FIFO_STATS_EN
        n_cmp++; if (debugout[15:8] !== 8'd1) begin n_err++; $display("FAIL unf_cnt got %0d exp 1", debugout[15:8]); end
`endif
    endtask

    task automatic test_timer_select();
        timer_select = 1'b1;
        push(32'hA1A2A3A4);
        tick0();
        n_cmp++; if (sample_valid !== 1'b0 || sample !== 8'h7F) begin n_err++; $display("FAIL tsel_t0_ignored got %h/%b exp 7f/0", sample, sample_valid); end
        n_cmp++; if (fill_bytes !== 6'd4) begin n_err++; $display("FAIL tsel_t0_fill got %0d exp 4", fill_bytes); end
        tick1();
        n_cmp++; if (sample_valid !== 1'b1 || sample !== 8'hA4) begin n_err++; $display("FAIL tsel_t1_pop got %h/%b exp a4/1", sample, sample_valid); end
        n_cmp++; if (fill_bytes !== 6'd3) begin n_err++; $display("FAIL tsel_t1_fill got %0d exp 3", fill_bytes); end
        for (int k = 0; k < 3; k++) tick1();
        n_cmp++; if (sample !== 8'hA1 || fill_bytes !== 6'd0) begin n_err++; $display("FAIL tsel_drain got %h/%0d exp a1/0", sample, fill_bytes); end
        timer_select = 1'b0;
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) push(mkw(8'h40, i));
        for (int k = 0; k < 3; k++) tick0();
        n_cmp++; if (fill_bytes !== 6'd29) begin n_err++; $display("FAIL simul_setup_full got %0d exp 29", fill_bytes); end
        // Full: pop frees the head word, push still rejected -> 7 words, bidx 0.
        fifo_wr = 1'b1; fifo_din = 32'hDEADBEEF; timer0_tick = 1'b1;
        step();
        fifo_wr = 1'b0; timer0_tick = 1'b0;
        n_cmp++; if (fill_bytes !== 6'd28) begin n_err++; $display("FAIL simul_full_fill got %0d exp 28", fill_bytes); end
        n_cmp++; if (sample !== 8'h43 || sample_valid !== 1'b1) begin n_err++; $display("FAIL simul_full_sample got %h/%b exp 43/1", sample, sample_valid); end
        n_cmp++; if (dma_req !== 1'b0) begin n_err++; $display("FAIL simul_full_dma got %b exp 0", dma_req); end
`ifdef GBA_SOUND_FIFO_STATS_EN
        n_cmp++; if (debugout[23:16] !== 8'd2) begin n_err++; $display("FAIL simul_ovf_cnt got %0d exp 2", debugout[23:16]); end
`endif
        for (int k = 0; k < 11; k++) tick0();
        n_cmp++; if (fill_bytes !== 6'd17) begin n_err++; $display("FAIL simul_setup_five got %0d exp 17", fill_bytes); end
        // 5 words: push accepted and pop frees a word -> still 5 words, bidx 0.
        fifo_wr = 1'b1; fifo_din = 32'h11223344; timer0_tick = 1'b1;
        step();
        fifo_wr = 1'b0; timer0_tick = 1'b0;
        n_cmp++; if (fill_bytes !== 6'd20) begin n_err++; $display("FAIL simul_five_fill got %0d exp 20", fill_bytes); end
        n_cmp++; if (sample !== 8'h4F) begin n_err++; $display("FAIL simul_five_sample got %h exp 4f", sample); end
    endtask

    task automatic test_clear_gb_on();
        fifo_clear = 1'b1;
        step();
        fifo_clear = 1'b0;
        n_cmp++; if (fill_bytes !== 6'd0) begin n_err++; $display("FAIL clr_empty got %0d exp 0", fill_bytes); end
        for (int i = 0; i < 3; i++) push(mkw(8'h80, i));
        tick0();
        tick0();
        n_cmp++; if (fill_bytes !== 6'd10 || sample !== 8'h81) begin n_err++; $display("FAIL clr_setup got %0d/%h exp 10/81", fill_bytes, sample); end
        fifo_clear = 1'b1; fifo_wr = 1'b1; fifo_din = 32'h55555555;
        step();
        fifo_clear = 1'b0; fifo_wr = 1'b0;
        n_cmp++; if (fill_bytes !== 6'd0) begin n_err++; $display("FAIL clr_fill got %0d exp 0", fill_bytes); end
        n_cmp++; if (sample !== 8'h81 || sample_valid !== 1'b0 || dma_req !== 1'b0) begin n_err++; $display("FAIL clr_outputs got %h/%b/%b exp 81/0/0", sample, sample_valid, dma_req); end
        push(32'hC3C2C1C0);
        tick0();
        n_cmp++; if (sample !== 8'hC0 || fill_bytes !== 6'd3) begin n_err++; $display("FAIL clr_refill got %h/%0d exp c0/3", sample, fill_bytes); end
        gb_on = 1'b0;
        push(32'h99999999);
        n_cmp++; if (fill_bytes !== 6'd3) begin n_err++; $display("FAIL gboff_push got %0d exp 3", fill_bytes); end
        tick0();
        n_cmp++; if (fill_bytes !== 6'd3 || sample_valid !== 1'b0 || sample !== 8'hC0) begin n_err++; $display("FAIL gboff_tick got %0d/%b/%h exp 3/0/c0", fill_bytes, sample_valid, sample); end
        fifo_clear = 1'b1;
        step();
        fifo_clear = 1'b0;
        n_cmp++; if (fill_bytes !== 6'd3) begin n_err++; $display("FAIL gboff_clear got %0d exp 3", fill_bytes); end
        gb_on = 1'b1;
        tick0();
        n_cmp++; if (sample !== 8'hC1 || fill_bytes !== 6'd2) begin n_err++; $display("FAIL gbon_resume got %h/%0d exp c1/2", sample, fill_bytes); end
`ifdef GBA_SOUND_FIFO_STATS_EN
        n_cmp++; if (debugout[23:8] !== 16'h0201) begin n_err++; $display("FAIL stats_final got %h exp 0201", debugout[23:8]); end
`endif
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_cmp        = 0;
        n_err        = 0;
        reset        = 1'b1;
        gb_on        = 1'b1;
        fifo_wr      = 1'b0;
        fifo_din     = 32'h0;
        fifo_clear   = 1'b0;
        timer_select = 1'b0;
        timer0_tick  = 1'b0;
        timer1_tick  = 1'b0;
        step();
        test_reset();
        test_basic_playback();
        test_overflow();
        test_underflow();
        test_timer_select();
        test_simultaneous();
        test_clear_gb_on();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
